multicycle_control_unit: RTL

//  Main FSM for the multi-cycle MIPS core; replaces hand-sequenced control stimulus of Data_Path.

---
 rtl/multicycle_control_unit.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_unit.sv
// Main control FSM for the multi-cycle MIPS core: decodes opcode/funct and sequences the datapath.
// Optional single-step mode (HALT after every instruction) is enabled by defining CU_SINGLE_STEP_EN.
module multicycle_control_unit #(
    parameter int unsigned ALU_OP_W = 3,
    parameter int unsigned MEM_LAT  = 0
) (
    input  logic                clk,
    input  logic                reset,
`ifdef CU_SINGLE_STEP_EN
    input  logic                step_i,
`endif
    input  logic [5:0]          opcode_i,
    input  logic [5:0]          funct_i,
    input  logic                zero_i,
    output logic                enable_PC,
    output logic                Selector_Addr,
    output logic                enable_MemSys,
    output logic                enable_RegIns,
    output logic                enable_RF,
    output logic                Selector_RF_WR,
    output logic                Selector_RF_WD,
    output logic                Selector_ALU_Src_A,
    output logic [1:0]          Selector_ALU_Src_B,
    output logic [ALU_OP_W-1:0] Selector_ALU_Op,
    output logic [1:0]          Selector_PC_Source,
    output logic                instr_done_o,
    output logic                illegal_o
);

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StExecR    = 4'd2,
        StAluWb    = 4'd3,
        StExecI    = 4'd4,
        StMemAddr  = 4'd5,
        StMemRead  = 4'd6,
        StMemWb    = 4'd7,
        StMemWrite = 4'd8,
        StBranch   = 4'd9,
        StJump     = 4'd10,
        StIllegal  = 4'd11
`ifdef CU_SINGLE_STEP_EN
        ,
        StHalt     = 4'd12
`endif
    } state_e;

`ifdef CU_SINGLE_STEP_EN
    localparam state_e ResetState = StHalt;
    localparam state_e DoneState  = StHalt;
`else
    localparam state_e ResetState = StFetch;
    localparam state_e DoneState  = StFetch;
`endif

    localparam logic [5:0] OpRType  = 6'h00;
    localparam logic [5:0] OpAddi   = 6'h08;
    localparam logic [5:0] OpLw     = 6'h23;
    localparam logic [5:0] OpSw     = 6'h2B;
    localparam logic [5:0] OpBeq    = 6'h04;
    localparam logic [5:0] OpJ      = 6'h02;

    localparam logic [5:0] FnAdd    = 6'h20;
    localparam logic [5:0] FnSub    = 6'h22;
    localparam logic [5:0] FnAnd    = 6'h24;
    localparam logic [5:0] FnOr     = 6'h25;
    localparam logic [5:0] FnSlt    = 6'h2A;

    localparam logic [ALU_OP_W-1:0] AluAnd = ALU_OP_W'(0);
    localparam logic [ALU_OP_W-1:0] AluAdd = ALU_OP_W'(1);
    localparam logic [ALU_OP_W-1:0] AluSub = ALU_OP_W'(2);
    localparam logic [ALU_OP_W-1:0] AluOr  = ALU_OP_W'(3);
    localparam logic [ALU_OP_W-1:0] AluSlt = ALU_OP_W'(4);

    localparam logic [3:0] WaitLast = 4'(MEM_LAT);

    state_e     state_q, state_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic       illegal_q;
    logic       wait_last;
    logic       pc_write;
    logic       branch_state;

    assign wait_last = (wait_cnt_q == WaitLast);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ResetState;
            wait_cnt_q <= 4'd0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (state_d == StIllegal) begin
                illegal_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d            = state_q;
        wait_cnt_d         = 4'd0;
        pc_write           = 1'b0;
        branch_state       = 1'b0;
        Selector_Addr      = 1'b0;
        enable_MemSys      = 1'b0;
        enable_RegIns      = 1'b0;
        enable_RF          = 1'b0;
        Selector_RF_WR     = 1'b0;
        Selector_RF_WD     = 1'b0;
        Selector_ALU_Src_A = 1'b0;
        Selector_ALU_Src_B = 2'b00;
        Selector_ALU_Op    = AluAnd;
        Selector_PC_Source = 2'b00;
        instr_done_o       = 1'b0;

        case (state_q)
            StFetch: begin
                Selector_ALU_Src_B = 2'b01;
                Selector_ALU_Op    = AluAdd;
                // IR and PC only latch once the memory has actually returned the word.
                if (wait_last) begin
                    pc_write      = 1'b1;
                    enable_RegIns = 1'b1;
                    state_d       = StDecode;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            StDecode: begin
                Selector_ALU_Src_B = 2'b11;
                Selector_ALU_Op    = AluAdd;
                case (opcode_i)
                    OpRType:    state_d = StExecR;
                    OpAddi:     state_d = StExecI;
                    OpLw, OpSw: state_d = StMemAddr;
                    OpBeq:      state_d = StBranch;
                    OpJ:        state_d = StJump;
                    default:    state_d = StIllegal;
                endcase
            end
            StExecR: begin
                Selector_ALU_Src_A = 1'b1;
                state_d            = StAluWb;
                case (funct_i)
                    FnAdd:   Selector_ALU_Op = AluAdd;
                    FnSub:   Selector_ALU_Op = AluSub;
                    FnAnd:   Selector_ALU_Op = AluAnd;
                    FnOr:    Selector_ALU_Op = AluOr;
                    FnSlt:   Selector_ALU_Op = AluSlt;
                    default: state_d = StIllegal;
                endcase
            end
            StAluWb: begin
                enable_RF      = 1'b1;
                Selector_RF_WR = (opcode_i == OpRType);
                instr_done_o   = 1'b1;
                state_d        = DoneState;
            end
            StExecI: begin
                Selector_ALU_Src_A = 1'b1;
                Selector_ALU_Src_B = 2'b10;
                Selector_ALU_Op    = AluAdd;
                state_d            = StAluWb;
            end
            StMemAddr: begin
                Selector_ALU_Src_A = 1'b1;
                Selector_ALU_Src_B = 2'b10;
                Selector_ALU_Op    = AluAdd;
                state_d            = (opcode_i == OpLw) ? StMemRead : StMemWrite;
            end
            StMemRead: begin
                Selector_Addr = 1'b1;
                if (wait_last) begin
                    state_d = StMemWb;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            StMemWb: begin
                enable_RF      = 1'b1;
                Selector_RF_WD = 1'b1;
                instr_done_o   = 1'b1;
                state_d        = DoneState;
            end
            StMemWrite: begin
                // Write enable is held for the whole access so slow memories see a stable request.
                Selector_Addr = 1'b1;
                enable_MemSys = 1'b1;
                if (wait_last) begin
                    instr_done_o = 1'b1;
                    state_d      = DoneState;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            StBranch: begin
                branch_state       = 1'b1;
                Selector_ALU_Src_A = 1'b1;
                Selector_ALU_Op    = AluSub;
                Selector_PC_Source = 2'b01;
                instr_done_o       = 1'b1;
                state_d            = DoneState;
            end
            StJump: begin
                pc_write           = 1'b1;
                Selector_PC_Source = 2'b10;
                instr_done_o       = 1'b1;
                state_d            = DoneState;
            end
            StIllegal: begin
                state_d = StIllegal;
            end
`ifdef CU_SINGLE_STEP_EN
            StHalt: begin
                if (step_i) begin
                    state_d = StFetch;
                end
            end
`endif
            default: begin
                state_d = StFetch;
            end
        endcase

        enable_PC = pc_write | (branch_state & zero_i);
        illegal_o = illegal_q;

        // Outputs are forced low during reset so an aborted access never issues a write.
        if (!reset) begin
            enable_PC          = 1'b0;
            Selector_Addr      = 1'b0;
            enable_MemSys      = 1'b0;
            enable_RegIns      = 1'b0;
            enable_RF          = 1'b0;
            Selector_RF_WR     = 1'b0;
            Selector_RF_WD     = 1'b0;
            Selector_ALU_Src_A = 1'b0;
            Selector_ALU_Src_B = 2'b00;
            Selector_ALU_Op    = AluAnd;
            Selector_PC_Source = 2'b00;
            instr_done_o       = 1'b0;
            illegal_o          = 1'b0;
        end
    end

endmodule
